// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the three-stage pipeline datapath and pipe_hazard_ctrl.
// master = the hazard controller, slave = the pipeline datapath it steers.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             jump_taken;
  logic [4:0]       exe_rs1;
  logic [4:0]       exe_rs2;
  logic [4:0]       mwb_rd;
  logic             mwb_reg_we;
  logic             mwb_dmem_req;
  logic             dmem_ready;

  logic             pc_sel_rst;
  logic             pc_hold;
  logic             ifexe_hold;
  logic             ifexe_flush;
  logic             exemwb_hold;
  logic             exemwb_bubble;
  logic             fwd_a;
  logic             fwd_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  jump_taken, exe_rs1, exe_rs2, mwb_rd, mwb_reg_we, mwb_dmem_req, dmem_ready,
    output pc_sel_rst, pc_hold, ifexe_hold, ifexe_flush, exemwb_hold, exemwb_bubble,
           fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    output jump_taken, exe_rs1, exe_rs2, mwb_rd, mwb_reg_we, mwb_dmem_req, dmem_ready,
    input  pc_sel_rst, pc_hold, ifexe_hold, ifexe_flush, exemwb_hold, exemwb_bubble,
           fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/flush/bubble sequencing, MWB->EXE forwarding and DMEM timeout trap.
// Optional perf counters are built when PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int MEM_TIMEOUT       = 15,
  parameter int CNT_W             = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.master  hz
);
  typedef enum logic [1:0] {RST_HOLD, RUN, MEM_WAIT, ERR} state_t;

  state_t      state_q, state_d, cur_state;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic        pc_sel_rst, hold_all, ifexe_flush, exemwb_bubble;
  logic        fwd_a, fwd_b, run_stall, counting;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    pc_sel_rst    = 1'b0;
    hold_all      = 1'b0;
    ifexe_flush   = 1'b0;
    exemwb_bubble = 1'b0;
    fwd_a         = 1'b0;
    fwd_b         = 1'b0;
    // Reset forces the RST_HOLD decode combinationally, whatever the stored state.
    cur_state     = rst ? RST_HOLD : state_q;
    run_stall     = hz.mwb_dmem_req & ~hz.dmem_ready;
    counting      = (cur_state == RUN) || (cur_state == MEM_WAIT);

    if (counting) begin
      fwd_a = hz.mwb_reg_we && (hz.mwb_rd != 5'd0) && (hz.mwb_rd == hz.exe_rs1);
      fwd_b = hz.mwb_reg_we && (hz.mwb_rd != 5'd0) && (hz.mwb_rd == hz.exe_rs2);
    end

    case (cur_state)
      RST_HOLD: begin
        pc_sel_rst    = 1'b1;
        ifexe_flush   = 1'b1;
        exemwb_bubble = 1'b1;
        if (hold_cnt_q == 32'(RESET_HOLD_CYCLES - 1)) begin
          state_d    = RUN;
          hold_cnt_d = 32'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      RUN: begin
        if (run_stall) begin
          hold_all   = 1'b1;
          wait_cnt_d = 32'd1;
          state_d    = (MEM_TIMEOUT == 1) ? ERR : MEM_WAIT;
        end else begin
          ifexe_flush = hz.jump_taken;
        end
      end
      MEM_WAIT: begin
        if (!hz.dmem_ready) begin
          hold_all = 1'b1;
          if (wait_cnt_q != 32'hFFFF_FFFF) wait_cnt_d = wait_cnt_q + 32'd1;
          if ((MEM_TIMEOUT != 0) && (wait_cnt_q + 32'd1 == 32'(MEM_TIMEOUT))) state_d = ERR;
        end else begin
          // The frozen EXE instruction re-presents any deferred jump here.
          ifexe_flush = hz.jump_taken;
          wait_cnt_d  = 32'd0;
          state_d     = RUN;
        end
      end
      default: begin
        hold_all      = 1'b1;
        exemwb_bubble = 1'b1;
      end
    endcase

    if (state_d == ERR) mem_timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST_HOLD;
      hold_cnt_q    <= 32'd0;
      wait_cnt_q    <= 32'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign hz.pc_sel_rst    = pc_sel_rst;
  assign hz.pc_hold       = hold_all;
  assign hz.ifexe_hold    = hold_all;
  assign hz.ifexe_flush   = ifexe_flush;
  assign hz.exemwb_hold   = hold_all;
  assign hz.exemwb_bubble = exemwb_bubble;
  assign hz.fwd_a         = fwd_a;
  assign hz.fwd_b         = fwd_b;
  assign hz.mem_timeout   = mem_timeout_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (counting && hold_all && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (counting && ifexe_flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-level behavioural model plus literal pins.
module tb_pipe_hazard_ctrl;
  localparam int RHC = 2;
  localparam int MT  = 15;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz();

  pipe_hazard_ctrl #(.RESET_HOLD_CYCLES(RHC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: remaining fill cycles, an access in flight, its stalled length, trap flag.
  int      fill_left = 0;
  bit      waiting   = 1'b0;
  int      stall_run = 0;
  bit      trapped   = 1'b0;
  longint  m_stall   = 0;
  longint  m_flush   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input string tag, input bit r, input bit j,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] rd,
                      input bit we, input bit req, input bit rdy);
    bit e_psr, e_hold, e_flush, e_bub, e_fa, e_fb, stalled;
    longint e_sc, e_fc;
    @(posedge clk);
    #1;
    rst = r;
    hz.jump_taken = j;  hz.exe_rs1 = s1; hz.exe_rs2 = s2; hz.mwb_rd = rd;
    hz.mwb_reg_we = we; hz.mwb_dmem_req = req; hz.dmem_ready = rdy;
    @(negedge clk);

    e_psr = 0; e_hold = 0; e_flush = 0; e_bub = 0; e_fa = 0; e_fb = 0; stalled = 0;
    if (r || fill_left > 0) begin
      e_psr = 1; e_flush = 1; e_bub = 1;
    end else if (trapped) begin
      e_hold = 1; e_bub = 1;
    end else begin
      stalled = !rdy && (waiting || req);
      e_hold  = stalled;
      e_flush = !stalled && j;
      e_fa    = we && (rd != 0) && (rd == s1);
      e_fb    = we && (rd != 0) && (rd == s2);
    end
`ifdef PERF_CNT_EN
    e_sc = m_stall; e_fc = m_flush;
`else
    e_sc = 0; e_fc = 0;
`endif
    chk({tag, ".pc_sel_rst"},    64'(hz.pc_sel_rst),    64'(e_psr));
    chk({tag, ".pc_hold"},       64'(hz.pc_hold),       64'(e_hold));
    chk({tag, ".ifexe_hold"},    64'(hz.ifexe_hold),    64'(e_hold));
    chk({tag, ".ifexe_flush"},   64'(hz.ifexe_flush),   64'(e_flush));
    chk({tag, ".exemwb_hold"},   64'(hz.exemwb_hold),   64'(e_hold));
    chk({tag, ".exemwb_bubble"}, 64'(hz.exemwb_bubble), 64'(e_bub));
    chk({tag, ".fwd_a"},         64'(hz.fwd_a),         64'(e_fa));
    chk({tag, ".fwd_b"},         64'(hz.fwd_b),         64'(e_fb));
    chk({tag, ".mem_timeout"},   64'(hz.mem_timeout),   64'(trapped));
    chk({tag, ".stall_cnt"},     64'(hz.stall_cnt),     64'(e_sc));
    chk({tag, ".flush_cnt"},     64'(hz.flush_cnt),     64'(e_fc));
    $display("%-10s rst=%0d j=%0d req=%0d rdy=%0d | psr=%0d hold=%0d flush=%0d bub=%0d fwd=%0d%0d mto=%0d sc=%0d fc=%0d",
             tag, r, j, req, rdy, hz.pc_sel_rst, hz.pc_hold, hz.ifexe_flush, hz.exemwb_bubble,
             hz.fwd_a, hz.fwd_b, hz.mem_timeout, hz.stall_cnt, hz.flush_cnt);

    if (r) begin
      fill_left = RHC; waiting = 0; stall_run = 0; trapped = 0; m_stall = 0; m_flush = 0;
    end else if (fill_left > 0) begin
      fill_left--;
    end else if (!trapped) begin
      if (stalled) begin
        stall_run++;
        waiting = 1;
        m_stall++;
        if (MT != 0 && stall_run >= MT) trapped = 1;
      end else begin
        waiting = 0;
        stall_run = 0;
      end
      if (e_flush) m_flush++;
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 1);
  endtask

  task automatic dmem(input string tag, input bit j, input bit rdy);
    step(tag, 0, j, 5'd1, 5'd2, 5'd3, 0, 1, rdy);
  endtask

  initial begin
    hz.jump_taken = 0; hz.exe_rs1 = 0; hz.exe_rs2 = 0; hz.mwb_rd = 0;
    hz.mwb_reg_we = 0; hz.mwb_dmem_req = 0; hz.dmem_ready = 1;

    // Reset and post-reset fill
    step("rst", 1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    chk("pin.rst_psr", 64'(hz.pc_sel_rst), 64'd1);
    idle("fill1");
    chk("pin.fill1_flush", 64'(hz.ifexe_flush), 64'd1);
    idle("fill2");
    chk("pin.fill2_psr", 64'(hz.pc_sel_rst), 64'd1);
    idle("run0");
    chk("pin.run0_psr", 64'(hz.pc_sel_rst), 64'd0);
    chk("pin.run0_flush", 64'(hz.ifexe_flush), 64'd0);

    // Three-cycle DMEM stall
    for (int i = 0; i < 3; i++) begin
      dmem("stall", 0, 0);
      chk("pin.stall_hold", 64'(hz.pc_hold), 64'd1);
    end
    dmem("ready", 0, 1);
    chk("pin.ready_hold", 64'(hz.exemwb_hold), 64'd0);
    idle("post_st");
`ifdef PERF_CNT_EN
    chk("pin.stall_cnt", 64'(hz.stall_cnt), 64'd3);
`else
    chk("pin.stall_cnt", 64'(hz.stall_cnt), 64'd0);
`endif

    // Jump pulse
    step("jump", 0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    chk("pin.jump_flush", 64'(hz.ifexe_flush), 64'd1);
    chk("pin.jump_hold", 64'(hz.ifexe_hold), 64'd0);
    idle("post_j");
    chk("pin.post_j_flush", 64'(hz.ifexe_flush), 64'd0);
`ifdef PERF_CNT_EN
    chk("pin.flush_cnt", 64'(hz.flush_cnt), 64'd1);
`endif

    // Forwarding
    step("fwd5", 0, 0, 5'd5, 5'd5, 5'd5, 1, 0, 1);
    chk("pin.fwd5_a", 64'(hz.fwd_a), 64'd1);
    chk("pin.fwd5_b", 64'(hz.fwd_b), 64'd1);
    step("fwd_x0", 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1);
    chk("pin.fwd_x0_a", 64'(hz.fwd_a), 64'd0);
    step("fwd_nwe", 0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 1);
    chk("pin.fwd_nwe_b", 64'(hz.fwd_b), 64'd0);
    step("fwd_a_only", 0, 0, 5'd7, 5'd8, 5'd7, 1, 0, 1);
    step("fwd_stall", 0, 0, 5'd9, 5'd9, 5'd9, 1, 1, 0);
    chk("pin.fwd_stall_b", 64'(hz.fwd_b), 64'd1);
    dmem("fwd_rel", 0, 1);

    // Stall with jump: flush deferred to the release cycle
    dmem("sj1", 1, 0);
    chk("pin.sj1_flush", 64'(hz.ifexe_flush), 64'd0);
    dmem("sj2", 1, 0);
    chk("pin.sj2_flush", 64'(hz.ifexe_flush), 64'd0);
    dmem("sj_rel", 1, 1);
    chk("pin.sj_rel_flush", 64'(hz.ifexe_flush), 64'd1);
    idle("post_sj");

    // Timeout: 15 stalled cycles trap into ERR
    for (int i = 0; i < MT; i++) dmem("to", 0, 0);
    chk("pin.to15_mto", 64'(hz.mem_timeout), 64'd0);
    idle("err1");
    chk("pin.err_mto", 64'(hz.mem_timeout), 64'd1);
    chk("pin.err_bub", 64'(hz.exemwb_bubble), 64'd1);
    chk("pin.err_flush", 64'(hz.ifexe_flush), 64'd0);
    step("err_jump", 0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    chk("pin.err_sticky", 64'(hz.mem_timeout), 64'd1);
    step("rst2", 1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    chk("pin.rst2_psr", 64'(hz.pc_sel_rst), 64'd1);
    idle("fill3");
    chk("pin.fill3_mto", 64'(hz.mem_timeout), 64'd0);
    idle("fill4");
    idle("run1");

    // Reset in the middle of a DMEM wait
    dmem("mw1", 0, 0);
    dmem("mw2", 0, 0);
    step("rst3", 1, 0, 5'd1, 5'd2, 5'd3, 0, 1, 0);
    chk("pin.rst3_hold", 64'(hz.pc_hold), 64'd0);
    idle("fill5");
    idle("fill6");
    idle("run2");
    chk("pin.run2_hold", 64'(hz.pc_hold), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
